// File: rtl/input_pkg.sv
// Shared keycodes, keymap and action/direction types for the player input controller.
// The optional report-to-report debounce is enabled with the KEY_DEBOUNCE_EN macro.
package input_pkg;

   typedef enum logic [2:0] {ActUp, ActLeft, ActDown, ActRight, ActBomb} action_e;
   typedef enum logic [2:0] {DirNone, DirUp, DirLeft, DirDown, DirRight} dir_e;

   localparam int unsigned NUM_ACTIONS = 5;

   localparam logic [7:0] KC_ROLLOVER = 8'd1;
   localparam logic [7:0] KC_W        = 8'd26;
   localparam logic [7:0] KC_A        = 8'd4;
   localparam logic [7:0] KC_S        = 8'd22;
   localparam logic [7:0] KC_D        = 8'd7;
   localparam logic [7:0] KC_P0_BOMB  = 8'd53;
   localparam logic [7:0] KC_UP       = 8'd82;
   localparam logic [7:0] KC_LEFT     = 8'd80;
   localparam logic [7:0] KC_DOWN     = 8'd81;
   localparam logic [7:0] KC_RIGHT    = 8'd79;
   localparam logic [7:0] KC_P1_BOMB  = 8'd54;

   // Indexed [player][action], actions ordered UP, LEFT, DOWN, RIGHT, BOMB.
   localparam logic [7:0] KEYMAP [2][5] = '{
      '{KC_W,  KC_A,    KC_S,    KC_D,     KC_P0_BOMB},
      '{KC_UP, KC_LEFT, KC_DOWN, KC_RIGHT, KC_P1_BOMB}
   };

   // Highest-priority direction in a {RIGHT, DOWN, LEFT, UP} mask.
   function automatic dir_e first_dir(logic [3:0] m);
      if (m[0])      return DirUp;
      else if (m[1]) return DirLeft;
      else if (m[2]) return DirDown;
      else if (m[3]) return DirRight;
      else           return DirNone;
   endfunction

   function automatic logic [3:0] dir_mask(dir_e d);
      case (d)
         DirUp:    return 4'b0001;
         DirLeft:  return 4'b0010;
         DirDown:  return 4'b0100;
         DirRight: return 4'b1000;
         default:  return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/player_action_fsm.sv
// Per-player direction tracking, bomb edge/cooldown and optional debounce (KEY_DEBOUNCE_EN).
module player_action_fsm
   import input_pkg::*;
#(
   parameter int unsigned PLAYER        = 0,
   parameter int unsigned BOMB_COOLDOWN = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       accept,
   input  logic [4:0] raw,
   output logic [7:0] move,
   output logic       bomb
);

   localparam int unsigned CdW = $clog2(BOMB_COOLDOWN + 1);

   dir_e           dir_q, dir_next;
   logic [4:0]     held_q, held_next, newly;
   logic [CdW-1:0] cd_q;

`ifdef KEY_DEBOUNCE_EN
   logic [4:0] db_q;
   // A bit only moves into held_q once two consecutive reports agree on it.
   assign held_next = ((raw ^ db_q) & held_q) | (~(raw ^ db_q) & raw);
`else
   assign held_next = raw;
`endif

   assign newly = held_next & ~held_q;

   function automatic logic [7:0] kc_of(dir_e d);
      case (d)
         DirUp:    return KEYMAP[PLAYER][0];
         DirLeft:  return KEYMAP[PLAYER][1];
         DirDown:  return KEYMAP[PLAYER][2];
         DirRight: return KEYMAP[PLAYER][3];
         default:  return 8'd0;
      endcase
   endfunction

   always_comb begin
      dir_next = dir_q;
      if (|newly[3:0]) begin
         dir_next = first_dir(newly[3:0]);
      end else if (!(|(held_next[3:0] & dir_mask(dir_q)))) begin
         dir_next = first_dir(held_next[3:0]);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         dir_q  <= DirNone;
         held_q <= '0;
         cd_q   <= '0;
         move   <= '0;
         bomb   <= 1'b0;
`ifdef KEY_DEBOUNCE_EN
         db_q   <= '0;
`endif
      end else begin
         bomb <= 1'b0;
         if (cd_q != '0) cd_q <= cd_q - 1'b1;
         if (accept) begin
            held_q <= held_next;
            dir_q  <= dir_next;
            move   <= kc_of(dir_next);
`ifdef KEY_DEBOUNCE_EN
            db_q   <= raw;
`endif
            // cd_q is tested before this clock's decrement, so 1->0 still blocks.
            if (newly[4] && cd_q == '0) begin
               bomb <= 1'b1;
               cd_q <= CdW'(BOMB_COOLDOWN);
            end
         end
      end
   end

endmodule

// File: rtl/player_input_ctrl.sv
// Keyboard report decoder: slot matching and rollover detection, one action FSM per player.
// Optional debounce inside each player FSM is enabled with KEY_DEBOUNCE_EN.
module player_input_ctrl
   import input_pkg::*;
#(
   parameter int unsigned NUM_SLOTS     = 6,
   parameter int unsigned NUM_PLAYERS   = 2,
   parameter int unsigned BOMB_COOLDOWN = 16
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         keys_valid,
   input  logic [8*NUM_SLOTS-1:0]       keycodes,
   output logic [NUM_PLAYERS-1:0][7:0]  move,
   output logic [NUM_PLAYERS-1:0]       bomb,
   output logic                         rollover_err
);

   logic [NUM_PLAYERS-1:0][4:0] raw_held;
   logic                        rollover_hit;
   logic                        accept;

   always_comb begin
      raw_held     = '0;
      rollover_hit = 1'b0;
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
         if (keycodes[8*s +: 8] == KC_ROLLOVER) rollover_hit = 1'b1;
         for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            for (int unsigned a = 0; a < NUM_ACTIONS; a++) begin
               if (keycodes[8*s +: 8] == KEYMAP[p][a]) raw_held[p][a] = 1'b1;
            end
         end
      end
   end

   // Phantom (ErrorRollOver) reports never reach the player state.
   assign accept = keys_valid & ~rollover_hit;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rollover_err <= 1'b0;
      end else if (keys_valid) begin
         rollover_err <= rollover_hit;
      end
   end

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      player_action_fsm #(
         .PLAYER        (p),
         .BOMB_COOLDOWN (BOMB_COOLDOWN)
      ) u_player (
         .Clk    (Clk),
         .Reset  (Reset),
         .accept (accept),
         .raw    (raw_held[p]),
         .move   (move[p]),
         .bomb   (bomb[p])
      );
   end

endmodule

// File: tb/tb_player_input_ctrl.sv
// Scoreboard bench for player_input_ctrl: directed test-plan reports plus random traffic.
module tb_player_input_ctrl;

   localparam int NS   = 6;
   localparam int NP   = 2;
   localparam int COOL = 16;

   typedef struct packed {
      logic [7:0] m0;
      logic [7:0] m1;
      logic [1:0] b;
      logic       err;
   } exp_t;

   logic                Clk = 1'b0;
   logic                Reset = 1'b1;
   logic                keys_valid = 1'b0;
   logic [8*NS-1:0]     keycodes = '0;
   logic [NP-1:0][7:0]  move;
   logic [NP-1:0]       bomb;
   logic                rollover_err;

   player_input_ctrl #(
      .NUM_SLOTS     (NS),
      .NUM_PLAYERS   (NP),
      .BOMB_COOLDOWN (COOL)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .keys_valid   (keys_valid),
      .keycodes     (keycodes),
      .move         (move),
      .bomb         (bomb),
      .rollover_err (rollover_err)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;
   exp_t sb[$];
   bit  done = 1'b0;

   // ---------------- reference model ----------------
   int  kc_tab[2][5] = '{'{26, 4, 22, 7, 53}, '{82, 80, 81, 79, 54}};
   bit  m_held[2][5];
   bit  m_last_raw[2][5];
   int  m_dir[2];
   int  m_last_fire[2];
   bit  m_err;
   int  edge_cnt = 0;

   function automatic void model_reset();
      for (int p = 0; p < 2; p++) begin
         for (int a = 0; a < 5; a++) begin
            m_held[p][a] = 0;
            m_last_raw[p][a] = 0;
         end
         m_dir[p] = -1;
         m_last_fire[p] = -100000;
      end
      m_err = 0;
   endfunction

   function automatic exp_t model_report(logic [8*NS-1:0] kc, int edge_no);
      exp_t e;
      int   slots[NS];
      bit   fired[2];
      bit   phantom = 0;
      for (int s = 0; s < NS; s++) begin
         slots[s] = int'(kc[8*s +: 8]);
         if (slots[s] == 1) phantom = 1;
      end
      fired[0] = 0;
      fired[1] = 0;
      if (phantom) begin
         m_err = 1;
      end else begin
         m_err = 0;
         for (int p = 0; p < NP; p++) begin
            bit raw[5];
            bit nh[5];
            int pick = -1;
            for (int a = 0; a < 5; a++) begin
               raw[a] = 0;
               for (int s = 0; s < NS; s++) if (slots[s] == kc_tab[p][a]) raw[a] = 1;
`ifdef KEY_DEBOUNCE_EN
               nh[a] = (raw[a] == m_last_raw[p][a]) ? raw[a] : m_held[p][a];
`else
               nh[a] = raw[a];
`endif
               m_last_raw[p][a] = raw[a];
            end
            for (int a = 0; a < 4; a++) if (pick < 0 && nh[a] && !m_held[p][a]) pick = a;
            if (pick >= 0) m_dir[p] = pick;
            else if (!(m_dir[p] >= 0 && nh[m_dir[p]])) begin
               m_dir[p] = -1;
               for (int a = 3; a >= 0; a--) if (nh[a]) m_dir[p] = a;
            end
            if (nh[4] && !m_held[p][4] && (edge_no - m_last_fire[p] > COOL)) begin
               fired[p] = 1;
               m_last_fire[p] = edge_no;
            end
            for (int a = 0; a < 5; a++) m_held[p][a] = nh[a];
         end
      end
      e.m0  = (m_dir[0] < 0) ? 8'd0 : 8'(kc_tab[0][m_dir[0]]);
      e.m1  = (m_dir[1] < 0) ? 8'd0 : 8'(kc_tab[1][m_dir[1]]);
      e.b   = {fired[1], fired[0]};
      e.err = m_err;
      return e;
   endfunction

   // ---------------- driver ----------------
   function automatic logic [8*NS-1:0] mk(int a, int b = 0, int c = 0);
      logic [8*NS-1:0] v = '0;
      v[7:0]   = 8'(a);
      v[15:8]  = 8'(b);
      v[23:16] = 8'(c);
      return v;
   endfunction

   // Inputs are applied 2 time units after a rising edge; the next edge consumes them.
   task automatic cyc(input bit rst, input bit kv, input logic [8*NS-1:0] kc);
      Reset      = rst;
      keys_valid = kv;
      keycodes   = kc;
      if (rst) model_reset();
      else if (kv) sb.push_back(model_report(kc, edge_cnt + 1));
      @(posedge Clk);
      edge_cnt++;
      #2;
   endtask

   task automatic rep(input logic [8*NS-1:0] kc);
      cyc(0, 1, kc);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, '0);
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      bit   kv, rs;
      exp_t e;
      while (!done) begin
         @(posedge Clk);
         kv = keys_valid;
         rs = Reset;
         #1;
         if (rs) begin
            n_cmp++;
            if (move != '0 || bomb != '0 || rollover_err != 1'b0) begin
               n_bad++;
               $display("FAIL reset_state: got move=%h bomb=%b err=%b, want all zero",
                        move, bomb, rollover_err);
            end
         end else if (kv) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL scoreboard_empty: got output with no expected entry, want entry");
            end else begin
               e = sb.pop_front();
               if (move[0] != e.m0 || move[1] != e.m1 || bomb != e.b || rollover_err != e.err) begin
                  n_bad++;
                  $display("FAIL report@%0t: got m0=%0d m1=%0d bomb=%b err=%b, want m0=%0d m1=%0d bomb=%b err=%b",
                           $time, move[0], move[1], bomb, rollover_err, e.m0, e.m1, e.b, e.err);
               end
            end
         end else begin
            n_cmp++;
            if (bomb != '0) begin
               n_bad++;
               $display("FAIL bomb_idle@%0t: got bomb=%b, want 00", $time, bomb);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int pool[13] = '{0, 0, 26, 4, 22, 7, 53, 82, 80, 81, 79, 54, 99};

   initial begin : stim
      logic [8*NS-1:0] kc;
      model_reset();
      @(posedge Clk);
      #2;
      cyc(1, 0, '0);
      cyc(1, 0, '0);

      // basic direction and fallback
      rep(mk(26));
      rep(mk(0));
      rep(mk(26));
      rep(mk(26, 7));
      rep(mk(26));
      rep(mk(0));
      rep(mk(4, 7, 82));
      rep(mk(0));

      // bomb pulse, hold, cooldown drop, later accept
      rep(mk(53));
      for (int i = 0; i < 5; i++) rep(mk(53));
      cyc(1, 0, '0);
      rep(mk(53));
      rep(mk(0));
      idle(1);
      rep(mk(53));
      rep(mk(0));
      idle(14);
      rep(mk(53));
      rep(mk(0));
      idle(2);
      rep(mk(53, 54));
      rep(mk(0));
      idle(13);
      rep(mk(54));

      // phantom report
      rep(mk(26));
      rep(mk(1, 26, 53));
      rep(mk(26));
      rep(mk(1));
      idle(3);
      rep(mk(0));

      // debounce glitch sequence
      rep(mk(22));
      rep(mk(0));
      rep(mk(22));
      rep(mk(22));
      rep(mk(0));
      rep(mk(0));

      // reset wins over keys_valid
      rep(mk(82, 53));
      rep(mk(82, 53));
      cyc(1, 1, mk(26, 54));
      rep(mk(53));

      // random traffic with occasional phantom and reset
      for (int i = 0; i < 600; i++) begin
         kc = '0;
         for (int s = 0; s < NS; s++) begin
            if ($urandom_range(0, 2) != 0) kc[8*s +: 8] = 8'(pool[$urandom_range(0, 12)]);
         end
         if ($urandom_range(0, 40) == 0) kc[8*$urandom_range(0, NS-1) +: 8] = 8'd1;
         if ($urandom_range(0, 150) == 0) cyc(1, $urandom_range(0, 1) == 1, kc);
         else cyc(0, $urandom_range(0, 3) != 0, kc);
      end
      idle(3);
      done = 1'b1;
      idle(1);
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_leftover: got %0d pending entries, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end

endmodule
